// File: rtl/conv_pkg.sv
// rtl/conv_pkg.sv - shared kernel constants and sequencer state type
// Exports: KERNEL_DIM, KERNEL_TAPS, ENGINE_LATENCY, seq_state_e.
package conv_pkg;

    localparam int KERNEL_DIM     = 3;
    localparam int KERNEL_TAPS    = 9;
    localparam int ENGINE_LATENCY = 10;

    typedef enum logic [2:0] {
        IDLE,
        FETCH,
        DRAIN,
        DONE,
        ERROR
    } seq_state_e;

endpackage

// File: rtl/conv_addr_gen.sv
// rtl/conv_addr_gen.sv - 3x3 window origin/tap counter and source address generator
// Ports: i_clk, i_rst (sync, active-high); i_advance steps to the next tap;
//        o_addr is the address of the current tap; o_last_tap / o_last_win
//        flag tap 8 of a window and the final window origin.
module conv_addr_gen
    import conv_pkg::*;
#(
    parameter int IMG_W  = 16,
    parameter int IMG_H  = 16,
    parameter int ADDR_W = 8
) (
    input  logic              i_clk,
    input  logic              i_rst,
    input  logic              i_advance,
    output logic [ADDR_W-1:0] o_addr,
    output logic              o_last_tap,
    output logic              o_last_win
);

    localparam logic [ADDR_W-1:0] C_MAX   = ADDR_W'(IMG_W - KERNEL_DIM);
    localparam logic [ADDR_W-1:0] R_MAX   = ADDR_W'(IMG_H - KERNEL_DIM);
    localparam logic [1:0]        TAP_MAX = 2'(KERNEL_DIM - 1);

    logic [ADDR_W-1:0] r_q, r_d, c_q, c_d;
    logic [1:0]        wr_q, wr_d, wc_q, wc_d;
    logic [ADDR_W-1:0] row, col;

    always_comb begin
        row        = r_q + ADDR_W'(wr_q);
        col        = c_q + ADDR_W'(wc_q);
        o_addr     = row * ADDR_W'(IMG_W) + col;
        o_last_tap = (wr_q == TAP_MAX) && (wc_q == TAP_MAX);
        o_last_win = (r_q == R_MAX) && (c_q == C_MAX);

        r_d  = r_q;
        c_d  = c_q;
        wr_d = wr_q;
        wc_d = wc_q;
        // Nested carry: tap column, tap row, origin column, origin row.
        // The final step wraps everything to zero, ready for the next frame.
        if (i_advance) begin
            if (wc_q != TAP_MAX) begin
                wc_d = wc_q + 2'd1;
            end else begin
                wc_d = 2'd0;
                if (wr_q != TAP_MAX) begin
                    wr_d = wr_q + 2'd1;
                end else begin
                    wr_d = 2'd0;
                    if (c_q != C_MAX) begin
                        c_d = c_q + ADDR_W'(1);
                    end else begin
                        c_d = '0;
                        r_d = (r_q != R_MAX) ? r_q + ADDR_W'(1) : '0;
                    end
                end
            end
        end
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_q  <= '0;
            c_q  <= '0;
            wr_q <= 2'd0;
            wc_q <= 2'd0;
        end else begin
            r_q  <= r_d;
            c_q  <= c_d;
            wr_q <= wr_d;
            wc_q <= wc_d;
        end
    end

endmodule

// File: rtl/conv_frame_sequencer.sv
// rtl/conv_frame_sequencer.sv - frame sequencer feeding 3x3 windows to a convolution engine
// Ports: i_clk, i_rst (sync, active-high); i_start / o_busy / o_done / o_err control;
//        o_rd_en / o_rd_addr / i_rd_data source RAM (1-cycle read latency);
//        o_conv_data / o_conv_valid samples to engine, i_conv_pixel / i_conv_valid results;
//        o_wr_en / o_wr_addr / o_wr_data result RAM.
module conv_frame_sequencer
    import conv_pkg::*;
#(
    parameter int IMG_W   = 16,
    parameter int IMG_H   = 16,
    parameter int ADDR_W  = 8,
    parameter int TIMEOUT = 64
) (
    input  logic              i_clk,
    input  logic              i_rst,
    input  logic              i_start,
    output logic              o_busy,
    output logic              o_done,
    output logic              o_err,
    output logic              o_rd_en,
    output logic [ADDR_W-1:0] o_rd_addr,
    input  logic [7:0]        i_rd_data,
    output logic [7:0]        o_conv_data,
    output logic              o_conv_valid,
    input  logic [7:0]        i_conv_pixel,
    input  logic              i_conv_valid,
    output logic              o_wr_en,
    output logic [ADDR_W-1:0] o_wr_addr,
    output logic [7:0]        o_wr_data
);

    localparam int                N_RESULTS = (IMG_W - 2) * (IMG_H - 2);
    localparam logic [ADDR_W-1:0] LAST_IDX  = ADDR_W'(N_RESULTS - 1);
    localparam int                TO_W      = $clog2(TIMEOUT + 1);
    localparam logic [TO_W-1:0]   TO_LAST   = TO_W'(TIMEOUT - 1);

    seq_state_e        state_q, state_d;
    logic              rd_en_q, rd_en_d;
    logic [ADDR_W-1:0] rd_addr_q, rd_addr_d;
    logic              rd_last_q, rd_last_d;
    logic              rd_vld_q, rd_vld_d;
    logic              conv_valid_q, conv_valid_d;
    logic [7:0]        conv_data_q, conv_data_d;
    logic              wr_en_q, wr_en_d;
    logic [ADDR_W-1:0] wr_addr_q, wr_addr_d;
    logic [7:0]        wr_data_q, wr_data_d;
    logic [ADDR_W-1:0] n_q, n_d;
    logic [TO_W-1:0]   to_cnt_q, to_cnt_d;
    logic              busy_q, busy_d;
    logic              done_q, done_d;
    logic              err_q, err_d;

    logic              issue;
    logic [ADDR_W-1:0] gen_addr;
    logic              gen_last_tap, gen_last_win;

    conv_addr_gen #(
        .IMG_W  (IMG_W),
        .IMG_H  (IMG_H),
        .ADDR_W (ADDR_W)
    ) u_addr_gen (
        .i_clk      (i_clk),
        .i_rst      (i_rst),
        .i_advance  (issue),
        .o_addr     (gen_addr),
        .o_last_tap (gen_last_tap),
        .o_last_win (gen_last_win)
    );

    always_comb begin
        state_d      = state_q;
        issue        = 1'b0;
        rd_en_d      = 1'b0;
        rd_addr_d    = rd_addr_q;
        rd_last_d    = 1'b0;
        // rd_vld tracks the cycle the RAM data is valid; the engine sees
        // that data and its strobe one register later, still contiguous.
        rd_vld_d     = rd_en_q;
        conv_valid_d = rd_vld_q;
        conv_data_d  = rd_vld_q ? i_rd_data : conv_data_q;
        wr_en_d      = 1'b0;
        wr_addr_d    = wr_addr_q;
        wr_data_d    = wr_data_q;
        n_d          = n_q;
        to_cnt_d     = to_cnt_q;
        err_d        = err_q;

        case (state_q)
            IDLE: begin
                if (i_start) begin
                    state_d  = FETCH;
                    issue    = 1'b1;
                    n_d      = '0;
                    to_cnt_d = '0;
                end
            end
            FETCH: begin
                // rd_last_q marks the cycle the final tap is on the bus.
                to_cnt_d = '0;
                if (rd_last_q) begin
                    state_d = DRAIN;
                end else begin
                    issue = 1'b1;
                end
            end
            DRAIN: begin
                if (i_conv_valid) begin
                    to_cnt_d = '0;
                end else if (to_cnt_q == TO_LAST) begin
                    state_d = ERROR;
                    err_d   = 1'b1;
                end else begin
                    to_cnt_d = to_cnt_q + TO_W'(1);
                end
            end
            DONE:    state_d = IDLE;
            ERROR:   state_d = ERROR;
            default: state_d = IDLE;
        endcase

        if (issue) begin
            rd_en_d   = 1'b1;
            rd_addr_d = gen_addr;
            rd_last_d = gen_last_tap && gen_last_win;
        end

        if (i_conv_valid) begin
            if (state_q == FETCH || state_q == DRAIN) begin
                wr_en_d   = 1'b1;
                wr_addr_d = n_q;
                wr_data_d = i_conv_pixel;
                n_d       = n_q + ADDR_W'(1);
                if (state_q == DRAIN && n_q == LAST_IDX) begin
                    state_d = DONE;
                end
            end else begin
                // A result with no frame in flight is a protocol error.
                err_d = 1'b1;
            end
        end

        busy_d = (state_d == FETCH) || (state_d == DRAIN);
        done_d = (state_d == DONE);
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            state_q      <= IDLE;
            rd_en_q      <= 1'b0;
            rd_addr_q    <= '0;
            rd_last_q    <= 1'b0;
            rd_vld_q     <= 1'b0;
            conv_valid_q <= 1'b0;
            conv_data_q  <= 8'd0;
            wr_en_q      <= 1'b0;
            wr_addr_q    <= '0;
            wr_data_q    <= 8'd0;
            n_q          <= '0;
            to_cnt_q     <= '0;
            busy_q       <= 1'b0;
            done_q       <= 1'b0;
            err_q        <= 1'b0;
        end else begin
            state_q      <= state_d;
            rd_en_q      <= rd_en_d;
            rd_addr_q    <= rd_addr_d;
            rd_last_q    <= rd_last_d;
            rd_vld_q     <= rd_vld_d;
            conv_valid_q <= conv_valid_d;
            conv_data_q  <= conv_data_d;
            wr_en_q      <= wr_en_d;
            wr_addr_q    <= wr_addr_d;
            wr_data_q    <= wr_data_d;
            n_q          <= n_d;
            to_cnt_q     <= to_cnt_d;
            busy_q       <= busy_d;
            done_q       <= done_d;
            err_q        <= err_d;
        end
    end

    assign o_busy       = busy_q;
    assign o_done       = done_q;
    assign o_err        = err_q;
    assign o_rd_en      = rd_en_q;
    assign o_rd_addr    = rd_addr_q;
    assign o_conv_data  = conv_data_q;
    assign o_conv_valid = conv_valid_q;
    assign o_wr_en      = wr_en_q;
    assign o_wr_addr    = wr_addr_q;
    assign o_wr_data    = wr_data_q;

endmodule

// File: tb/tb_conv_frame_sequencer.sv
// tb/tb_conv_frame_sequencer.sv - self-checking bench for conv_frame_sequencer
module tb_conv_frame_sequencer;
    import conv_pkg::*;

    localparam int W     = 4;
    localparam int H     = 4;
    localparam int AW    = 4;
    localparam int TO    = 24;
    localparam int NRES  = (W - 2) * (H - 2);
    localparam int NREAD = NRES * KERNEL_TAPS;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          start = 1'b0;
    logic          inj_valid = 1'b0;
    logic          eng_mute = 1'b0;
    logic          o_busy, o_done, o_err, o_rd_en, o_conv_valid, o_wr_en;
    logic [AW-1:0] o_rd_addr, o_wr_addr;
    logic [7:0]    o_conv_data, o_wr_data;
    logic [7:0]    rd_data = 8'd0;
    logic          eng_valid;
    logic [7:0]    eng_px;
    logic          conv_in_valid;

    always #5 clk = ~clk;

    conv_frame_sequencer #(
        .IMG_W(W), .IMG_H(H), .ADDR_W(AW), .TIMEOUT(TO)
    ) dut (
        .i_clk(clk), .i_rst(rst), .i_start(start),
        .o_busy(o_busy), .o_done(o_done), .o_err(o_err),
        .o_rd_en(o_rd_en), .o_rd_addr(o_rd_addr), .i_rd_data(rd_data),
        .o_conv_data(o_conv_data), .o_conv_valid(o_conv_valid),
        .i_conv_pixel(eng_px), .i_conv_valid(conv_in_valid),
        .o_wr_en(o_wr_en), .o_wr_addr(o_wr_addr), .o_wr_data(o_wr_data)
    );

    // Source RAM: one-cycle read latency.
    logic [7:0] mem [W*H];
    always @(posedge clk) if (o_rd_en) rd_data <= mem[o_rd_addr];

    // Engine model: 3x3 mean over each 9-sample run, ENGINE_LATENCY cycles later.
    logic [3:0]                tap;
    logic [11:0]               acc;
    logic [ENGINE_LATENCY-1:0] vpipe;
    logic [7:0]                ppipe [ENGINE_LATENCY];
    always @(posedge clk) begin
        logic       nv;
        logic [7:0] np;
        nv = 1'b0;
        np = 8'd0;
        if (rst) begin
            tap   <= 4'd0;
            acc   <= 12'd0;
            vpipe <= '0;
        end else begin
            if (o_conv_valid) begin
                if (tap == 4'(KERNEL_TAPS - 1)) begin
                    tap <= 4'd0;
                    acc <= 12'd0;
                    nv  = !eng_mute;
                    np  = 8'((acc + 12'(o_conv_data)) / 12'(KERNEL_TAPS));
                end else begin
                    tap <= tap + 4'd1;
                    acc <= acc + 12'(o_conv_data);
                end
            end
            vpipe <= {vpipe[ENGINE_LATENCY-2:0], nv};
            for (int i = ENGINE_LATENCY - 1; i > 0; i--) ppipe[i] <= ppipe[i-1];
            ppipe[0] <= np;
        end
    end
    assign eng_valid     = vpipe[ENGINE_LATENCY-1];
    assign eng_px        = ppipe[ENGINE_LATENCY-1];
    assign conv_in_valid = eng_valid | inj_valid;

    int n_pass = 0, n_fail = 0, n_total = 0;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_total++;
        assert (obs === exp) n_pass++;
        else begin
            n_fail++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    // Scoreboards and monitors.
    logic [AW-1:0] exp_addr [$];
    logic [15:0]   exp_wr [$];
    int rd_count = 0, wr_count = 0, done_count = 0, run = 0, max_run = 0, log_n = 0;
    logic [AW-1:0] rd_log [12];

    always @(negedge clk) begin
        if (o_rd_en) begin
            rd_count++;
            run++;
            if (log_n < 12) rd_log[log_n] = o_rd_addr;
            log_n++;
            check("rd_expected", 32'(exp_addr.size() != 0), 1);
            if (exp_addr.size() != 0) check("rd_addr", 32'(o_rd_addr), 32'(exp_addr.pop_front()));
        end else begin
            if (run > max_run) max_run = run;
            run = 0;
        end
        if (o_wr_en) begin
            logic [15:0] e;
            wr_count++;
            check("wr_expected", 32'(exp_wr.size() != 0), 1);
            if (exp_wr.size() != 0) begin
                e = exp_wr.pop_front();
                check("wr_addr", 32'(o_wr_addr), 32'(e[15:8]));
                check("wr_data", 32'(o_wr_data), 32'(e[7:0]));
            end
        end
        if (o_done) done_count++;
    end

    task automatic cyc(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic do_reset();
        rst = 1'b1;
        start = 1'b0;
        inj_valid = 1'b0;
        cyc(2);
        exp_addr.delete();
        exp_wr.delete();
        check("rst_busy", 32'(o_busy), 0);
        check("rst_done", 32'(o_done), 0);
        check("rst_err", 32'(o_err), 0);
        check("rst_rd_en", 32'(o_rd_en), 0);
        check("rst_conv_valid", 32'(o_conv_valid), 0);
        check("rst_wr_en", 32'(o_wr_en), 0);
        check("rst_rd_addr", 32'(o_rd_addr), 0);
        check("rst_wr_addr", 32'(o_wr_addr), 0);
        check("rst_wr_data", 32'(o_wr_data), 0);
        check("rst_conv_data", 32'(o_conv_data), 0);
        rst = 1'b0;
        cyc(1);
    endtask

    // Push expected reads and (optionally) results, then pulse i_start.
    task automatic frame_begin(input bit with_results);
        int n = 0;
        rd_count = 0; wr_count = 0; done_count = 0; max_run = 0; log_n = 0;
        for (int r = 0; r <= H - KERNEL_DIM; r++) begin
            for (int c = 0; c <= W - KERNEL_DIM; c++) begin
                int sum = 0;
                for (int wr = 0; wr < KERNEL_DIM; wr++) begin
                    for (int wc = 0; wc < KERNEL_DIM; wc++) begin
                        exp_addr.push_back(AW'((r + wr) * W + c + wc));
                        sum += int'(mem[(r + wr) * W + c + wc]);
                    end
                end
                if (with_results) exp_wr.push_back({8'(n), 8'(sum / KERNEL_TAPS)});
                n++;
            end
        end
        start = 1'b1;
        cyc(1);
        start = 1'b0;
    endtask

    task automatic frame_wait(input string tag);
        int k = 0;
        while (done_count == 0 && k < 400) begin
            cyc(1);
            k++;
        end
        check({tag, "_done_seen"}, 32'(k < 400), 1);
        cyc(4);
        check({tag, "_reads"}, 32'(rd_count), NREAD);
        check({tag, "_writes"}, 32'(wr_count), NRES);
        check({tag, "_done_count"}, 32'(done_count), 1);
        check({tag, "_busy_after"}, 32'(o_busy), 0);
        check({tag, "_rd_run"}, 32'(max_run), NREAD);
        check({tag, "_wr_left"}, 32'(exp_wr.size()), 0);
    endtask

    initial begin
        int j;
        logic [AW-1:0] exp_seq [12];
        int wr0;

        exp_seq = '{4'd0, 4'd1, 4'd2, 4'd4, 4'd5, 4'd6, 4'd8, 4'd9, 4'd10, 4'd1, 4'd2, 4'd3};

        // Uniform image, full frame.
        for (int i = 0; i < W * H; i++) mem[i] = 8'd9;
        do_reset();
        frame_begin(1'b1);
        frame_wait("flat");
        check("flat_err", 32'(o_err), 0);

        // Pixel = address: read order and per-window means 5,6,9,10.
        for (int i = 0; i < W * H; i++) mem[i] = 8'(i);
        frame_begin(1'b1);
        frame_wait("ramp");
        for (int i = 0; i < 12; i++) check("ramp_seq", 32'(rd_log[i]), 32'(exp_seq[i]));
        check("ramp_err", 32'(o_err), 0);

        // Reset mid-FETCH, then a clean frame.
        frame_begin(1'b1);
        cyc(10);
        check("midrst_busy_before", 32'(o_busy), 1);
        do_reset();
        frame_begin(1'b1);
        frame_wait("midrst");
        check("midrst_err", 32'(o_err), 0);

        // Second start during FETCH ignored; spurious result in IDLE flags error.
        frame_begin(1'b1);
        cyc(5);
        start = 1'b1;
        cyc(1);
        start = 1'b0;
        frame_wait("restart");
        cyc(20);
        check("restart_no_second_frame", 32'(rd_count), NREAD);
        check("restart_err_clear", 32'(o_err), 0);
        wr0 = wr_count;
        inj_valid = 1'b1;
        cyc(1);
        inj_valid = 1'b0;
        cyc(3);
        check("spurious_err", 32'(o_err), 1);
        check("spurious_no_write", 32'(wr_count), 32'(wr0));
        check("spurious_busy", 32'(o_busy), 0);

        // Engine never answers: ERROR exactly TO cycles after FETCH ends.
        do_reset();
        eng_mute = 1'b1;
        frame_begin(1'b0);
        j = 0;
        while (o_rd_en === 1'b1 && j < 200) begin
            cyc(1);
            j++;
        end
        check("to_fetch_end", 32'(j < 200), 1);
        check("to_drain_busy", 32'(o_busy), 1);
        j = 0;
        while (o_err !== 1'b1 && j < 200) begin
            cyc(1);
            j++;
        end
        check("to_cycles", 32'(j), TO);
        check("to_busy", 32'(o_busy), 0);
        start = 1'b1;
        cyc(1);
        start = 1'b0;
        cyc(5);
        check("to_err_sticky", 32'(o_err), 1);
        check("to_start_ignored", 32'(o_busy), 0);
        check("to_no_reads", 32'(rd_count), NREAD);
        check("to_no_writes", 32'(wr_count), 0);
        eng_mute = 1'b0;
        do_reset();

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
